// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flush/freeze controller with a DEPTH-entry writeback scoreboard.
// Define PIPELINE_CTRL_FORWARD_EN to enable operand forwarding (load-use stalls only).
module pipeline_ctrl #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idValid,
  input  logic [REG_W-1:0] idRn,
  input  logic [REG_W-1:0] idRm,
  input  logic             idTwoSrc,
  input  logic             idWbEn,
  input  logic             idMemRead,
  input  logic [REG_W-1:0] idDest,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             hazard,
  output logic             flush,
  output logic             freezeAll,
  output logic [2:0]       fwdSel1,
  output logic [2:0]       fwdSel2,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  typedef struct packed {
    logic             valid;
    logic             wbEn;
    logic             memRead;
    logic [REG_W-1:0] dest;
  } entry_t;

  entry_t [DEPTH-1:0] sbQ, sbD;
  logic   [CNT_W-1:0] stallCntQ, stallCntD;
  logic   [CNT_W-1:0] flushCntQ, flushCntD;

  logic [DEPTH-1:0] matchRn, matchRm, memReadVec;
  logic             hazRaw;
  logic             unusedMemRead;

  always_comb begin
    matchRn    = '0;
    matchRm    = '0;
    memReadVec = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      matchRn[i]    = sbQ[i].valid & sbQ[i].wbEn & (sbQ[i].dest == idRn);
      matchRm[i]    = sbQ[i].valid & sbQ[i].wbEn & (sbQ[i].dest == idRm);
      memReadVec[i] = sbQ[i].memRead;
    end
  end

  // Older entries' load flags only travel down the shift chain.
  assign unusedMemRead = ^memReadVec;

  assign freezeAll = memReq & ~memReady;

`ifdef PIPELINE_CTRL_FORWARD_EN
  // Forwarding covers everything except a load result still in EX.
  assign hazRaw = idValid & sbQ[0].memRead & (matchRn[0] | (idTwoSrc & matchRm[0]));

  always_comb begin
    fwdSel1 = 3'd0;
    fwdSel2 = 3'd0;
    // Walk oldest to youngest so the youngest match overwrites.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (matchRn[i]) fwdSel1 = 3'(i + 1);
      if (matchRm[i]) fwdSel2 = 3'(i + 1);
    end
    if (!idValid) begin
      fwdSel1 = 3'd0;
      fwdSel2 = 3'd0;
    end
  end
`else
  assign hazRaw  = idValid & ((|matchRn) | (idTwoSrc & (|matchRm)));
  assign fwdSel1 = 3'd0;
  assign fwdSel2 = 3'd0;
`endif

  // A taken branch squashes the stalled instruction, so flush beats hazard.
  assign flush  = ~rst & ~freezeAll & branchTaken;
  assign hazard = ~rst & ~freezeAll & ~branchTaken & hazRaw;

  always_comb begin
    sbD = sbQ;
    if (!freezeAll) begin
      if (hazard || flush) begin
        sbD[0] = '0;
      end else begin
        sbD[0] = {idValid, idWbEn, idMemRead, idDest};
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        sbD[i] = sbQ[i-1];
      end
    end
  end

  always_comb begin
    stallCntD = stallCntQ;
    flushCntD = flushCntQ;
    if (hazard && (stallCntQ != '1)) stallCntD = stallCntQ + CNT_W'(1);
    if (flush && (flushCntQ != '1))  flushCntD = flushCntQ + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbQ       <= '0;
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      sbQ       <= sbD;
      stallCntQ <= stallCntD;
      flushCntQ <= flushCntD;
    end
  end

  assign stallCount = stallCntQ;
  assign flushCount = flushCntQ;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; expected outputs go through a queue to a monitor.
// Covers PIPELINE_CTRL_FORWARD_EN builds with a separate vector list.
module tb_pipeline_ctrl;

  localparam int unsigned REG_W = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic       hazard;
    logic       flush;
    logic       freezeAll;
    logic [2:0] fwdSel1;
    logic [2:0] fwdSel2;
    logic [3:0] stallCount;
    logic [3:0] flushCount;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             idValid;
  logic [REG_W-1:0] idRn;
  logic [REG_W-1:0] idRm;
  logic             idTwoSrc;
  logic             idWbEn;
  logic             idMemRead;
  logic [REG_W-1:0] idDest;
  logic             branchTaken;
  logic             memReq;
  logic             memReady;
  logic             hazard;
  logic             flush;
  logic             freezeAll;
  logic [2:0]       fwdSel1;
  logic [2:0]       fwdSel2;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  exp_t  expQ[$];
  string nameQ[$];
  exp_t  expCur;
  exp_t  actCur;
  string nameCur;
  int    checks = 0;
  int    errors = 0;

  pipeline_ctrl #(
    .REG_W(REG_W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .idValid    (idValid),
    .idRn       (idRn),
    .idRm       (idRm),
    .idTwoSrc   (idTwoSrc),
    .idWbEn     (idWbEn),
    .idMemRead  (idMemRead),
    .idDest     (idDest),
    .branchTaken(branchTaken),
    .memReq     (memReq),
    .memReady   (memReady),
    .hazard     (hazard),
    .flush      (flush),
    .freezeAll  (freezeAll),
    .fwdSel1    (fwdSel1),
    .fwdSel2    (fwdSel2),
    .stallCount (stallCount),
    .flushCount (flushCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the edge and queue the outputs expected in that cycle.
  task automatic vec(input string nm, input logic r, input logic v, input int rn, input int rm,
                     input logic two, input logic wb, input logic mr, input int dst,
                     input logic br, input logic mq, input logic mrdy, input logic eh,
                     input logic ef, input logic ez, input int ef1, input int ef2,
                     input int esc, input int efc);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    idValid     = v;
    idRn        = 4'(rn);
    idRm        = 4'(rm);
    idTwoSrc    = two;
    idWbEn      = wb;
    idMemRead   = mr;
    idDest      = 4'(dst);
    branchTaken = br;
    memReq      = mq;
    memReady    = mrdy;
    e.hazard     = eh;
    e.flush      = ef;
    e.freezeAll  = ez;
    e.fwdSel1    = 3'(ef1);
    e.fwdSel2    = 3'(ef2);
    e.stallCount = 4'(esc);
    e.flushCount = 4'(efc);
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      expCur  = expQ.pop_front();
      nameCur = nameQ.pop_front();
      actCur.hazard     = hazard;
      actCur.flush      = flush;
      actCur.freezeAll  = freezeAll;
      actCur.fwdSel1    = fwdSel1;
      actCur.fwdSel2    = fwdSel2;
      actCur.stallCount = stallCount;
      actCur.flushCount = flushCount;
      checks++;
      if (actCur !== expCur) begin
        errors++;
        $display("FAIL %s got haz=%0b fl=%0b frz=%0b f1=%0d f2=%0d sc=%0d fc=%0d need haz=%0b fl=%0b frz=%0b f1=%0d f2=%0d sc=%0d fc=%0d",
                 nameCur, actCur.hazard, actCur.flush, actCur.freezeAll, actCur.fwdSel1,
                 actCur.fwdSel2, actCur.stallCount, actCur.flushCount, expCur.hazard,
                 expCur.flush, expCur.freezeAll, expCur.fwdSel1, expCur.fwdSel2,
                 expCur.stallCount, expCur.flushCount);
      end
    end
  end

  initial begin
    rst = 1'b1; idValid = 1'b0; idRn = '0; idRm = '0; idTwoSrc = 1'b0; idWbEn = 1'b0;
    idMemRead = 1'b0; idDest = '0; branchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0;
    //    name             r  v  rn rm 2s wb mr dst br mq mr   hz fl fz f1 f2 sc fc
`ifdef PIPELINE_CTRL_FORWARD_EN
    vec("rst_out",        1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vec("add_r5",         0, 1, 0, 0, 0, 1, 0, 5,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vec("use_fwd",        0, 1, 5, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
    vec("ld_r5",          0, 1, 0, 0, 0, 1, 1, 5,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vec("load_use",       0, 1, 5, 0, 0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 1, 0, 0, 0);
    vec("ld_fwd",         0, 1, 5, 5, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2, 2, 1, 0);
    vec("add_r5b",        0, 1, 0, 0, 0, 1, 0, 5,  0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
    vec("add_r5c",        0, 1, 5, 0, 0, 1, 0, 5,  0, 0, 0,   0, 0, 0, 1, 0, 1, 0);
    vec("youngest",       0, 1, 5, 5, 1, 1, 0, 5,  0, 0, 0,   0, 0, 0, 1, 1, 1, 0);
    vec("no_id",          0, 0, 5, 5, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
    vec("frz_fwd",        0, 1, 5, 0, 0, 0, 0, 0,  0, 1, 0,   0, 0, 1, 2, 0, 1, 0);
    vec("frz_end",        0, 1, 5, 0, 0, 0, 0, 0,  0, 1, 1,   0, 0, 0, 2, 0, 1, 0);
`else
    vec("rst_out",        1, 1, 0, 0, 0, 1, 0, 3,  1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vec("wr_r3",          0, 1, 0, 0, 0, 1, 0, 3,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vec("raw_e0",         0, 1, 3, 0, 0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    vec("raw_e1",         0, 1, 3, 0, 0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 1, 0);
    vec("raw_clear",      0, 1, 3, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 2, 0);
    vec("bubble_id",      0, 0, 0, 0, 0, 1, 0, 5,  0, 0, 0,   0, 0, 0, 0, 0, 2, 0);
    vec("wr_r7",          0, 1, 0, 0, 0, 1, 0, 7,  0, 0, 0,   0, 0, 0, 0, 0, 2, 0);
    vec("flush_wins",     0, 1, 7, 0, 0, 1, 0, 9,  1, 0, 0,   0, 1, 0, 0, 0, 2, 0);
    vec("after_flush",    0, 1, 9, 7, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 2, 1);
    vec("wr_r4",          0, 1, 0, 0, 0, 1, 0, 4,  0, 0, 0,   0, 0, 0, 0, 0, 2, 1);
    vec("rm_e0",          0, 1, 1, 4, 1, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 2, 1);
    vec("rm_e1",          0, 1, 1, 4, 1, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 3, 1);
    vec("rm_clear",       0, 1, 1, 4, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 4, 1);
    vec("wr_r6",          0, 1, 0, 0, 0, 1, 0, 6,  0, 0, 0,   0, 0, 0, 0, 0, 4, 1);
    vec("frz1",           0, 1, 6, 0, 0, 0, 0, 0,  0, 1, 0,   0, 0, 1, 0, 0, 4, 1);
    vec("frz2_br",        0, 1, 6, 0, 0, 0, 0, 0,  1, 1, 0,   0, 0, 1, 0, 0, 4, 1);
    vec("frz3",           0, 1, 6, 0, 0, 0, 0, 0,  0, 1, 0,   0, 0, 1, 0, 0, 4, 1);
    vec("frz_release",    0, 1, 6, 0, 0, 0, 0, 0,  0, 1, 1,   1, 0, 0, 0, 0, 4, 1);
    vec("resume_e1",      0, 1, 6, 0, 0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 5, 1);
    vec("resume_clear",   0, 1, 6, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 6, 1);
    // Two stalls per group; stallCount reaches 15 in group 4 and must hold there.
    for (int g = 0; g < 6; g++) begin
      int s0, s1;
      s0 = (6 + 2 * g > 15) ? 15 : 6 + 2 * g;
      s1 = (7 + 2 * g > 15) ? 15 : 7 + 2 * g;
      vec("sat_wr",       0, 1, 0, 0, 0, 1, 0, 2,  0, 0, 0,   0, 0, 0, 0, 0, s0, 1);
      vec("sat_rd0",      0, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, s0, 1);
      vec("sat_rd1",      0, 1, 2, 0, 0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, s1, 1);
    end
    for (int k = 0; k < 16; k++) begin
      vec("fl_sat",       0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,   0, 1, 0, 0, 0, 15,
          (k + 1 > 15) ? 15 : k + 1);
    end
    vec("fl_idle",        0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 15, 15);
    vec("fill_r8",        0, 1, 0, 0, 0, 1, 0, 8,  0, 0, 0,   0, 0, 0, 0, 0, 15, 15);
    vec("fill_r9",        0, 1, 0, 0, 0, 1, 0, 9,  0, 0, 0,   0, 0, 0, 0, 0, 15, 15);
    vec("rst_pre_frz",    0, 1, 8, 0, 0, 0, 0, 0,  0, 1, 0,   0, 0, 1, 0, 0, 15, 15);
    vec("rst_in_frz",     1, 1, 8, 0, 0, 0, 0, 0,  0, 1, 0,   0, 0, 1, 0, 0, 0, 0);
    vec("rst_idle",       1, 1, 8, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vec("post_rst",       0, 1, 8, 0, 0, 1, 0, 8,  0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vec("post_raw0",      0, 1, 8, 0, 0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    vec("post_raw1",      0, 1, 8, 0, 0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 1, 0);
    vec("post_clear",     0, 1, 8, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 2, 0);
`endif
    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending need 0 pending", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
